// File: rtl/median_pkg.sv
// median_pkg
// Shared definitions for the median filter scan controller: the controller
// state encoding, default image/window geometry, and the width of the
// line-buffer select field.
// No ports (package).
package median_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int WIN_DEF   = 3;

    // Enough for WIN-1 line buffers with WIN up to 5.
    localparam int LB_SEL_W  = 2;

endpackage

// File: rtl/median_scan_ctrl_if.sv
// median_scan_ctrl_if
// Bundles the pixel handshake, line-buffer write bus and window/status flags
// of the scan controller.
// Modports:
//   master - pixel source side: drives start, pix_valid; observes the rest
//   slave  - scan controller side: drives pix_ready, busy, lb_wr_en, lb_addr,
//            lb_sel, win_valid, win_row, win_col, eol, done
interface median_scan_ctrl_if
    import median_pkg::*;
#(
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) ();

    logic                start;
    logic                pix_valid;
    logic                pix_ready;
    logic                busy;
    logic                lb_wr_en;
    logic [COL_W-1:0]    lb_addr;
    logic [LB_SEL_W-1:0] lb_sel;
    logic                win_valid;
    logic [ROW_W-1:0]    win_row;
    logic [COL_W-1:0]    win_col;
    logic                eol;
    logic                done;

    modport master (
        output start, pix_valid,
        input  pix_ready, busy, lb_wr_en, lb_addr, lb_sel,
               win_valid, win_row, win_col, eol, done
    );

    modport slave (
        input  start, pix_valid,
        output pix_ready, busy, lb_wr_en, lb_addr, lb_sel,
               win_valid, win_row, win_col, eol, done
    );

endinterface

// File: rtl/median_scan_cnt.sv
// median_scan_cnt
// Wrapping up-counter used for the column, row and line-buffer select
// counters of the scan controller. Counts 0..MAX and wraps to 0.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (count -> 0)
//   load   in   synchronous clear (count -> 0), overrides inc
//   inc    in   advance by one, wrapping after MAX
//   count  out  current value
//   tc     out  terminal count, high while count == MAX
module median_scan_cnt #(
    parameter int W   = 4,
    parameter int MAX = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MAX);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/median_scan_ctrl.sv
// median_scan_ctrl
// Raster-scan controller for the median filter pipeline. Accepts one pixel
// per handshake, tracks column/row position with cascaded counters, drives
// the line-buffer write strobe/address/select and flags each pixel that
// completes a WIN x WIN window, reporting that window's centre.
// Optional feature macro: MEDIAN_SCAN_ABORT_EN (adds the abort input).
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   abort  in   abandon current frame (only with MEDIAN_SCAN_ABORT_EN)
//   bus    slave modport of median_scan_ctrl_if (handshake, line-buffer
//          write bus, window and status flags)
module median_scan_ctrl
    import median_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int COL_W = 10,
    parameter int ROW_W = 9,
    parameter int WIN   = WIN_DEF
) (
    input logic clk,
    input logic reset,
`ifdef MEDIAN_SCAN_ABORT_EN
    input logic abort,
`endif
    median_scan_ctrl_if.slave bus
);

    localparam int HALF = (WIN - 1) / 2;
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN - 1);
    localparam logic [COL_W-1:0] COL_HALF  = COL_W'(HALF);
    localparam logic [ROW_W-1:0] ROW_HALF  = ROW_W'(HALF);

    scan_state_t         state;
    logic                pix_ready_q;
    logic                busy_q;
    logic                win_valid_q;
    logic                eol_q;
    logic                done_q;
    logic [ROW_W-1:0]    win_row_q;
    logic [COL_W-1:0]    win_col_q;

    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [LB_SEL_W-1:0] lb_sel;
    logic                col_tc;
    logic                row_tc;
    logic                unused_lb_tc;

    logic                accept;
    logic                kill;
    logic                advance;
    logic                clear;

    assign accept = bus.pix_valid & pix_ready_q;

`ifdef MEDIAN_SCAN_ABORT_EN
    assign kill = abort & (state == RUN);
`else
    assign kill = 1'b0;
`endif

    // An abort beats a simultaneous accept, so the pixel is never counted.
    assign advance = accept & ~kill;

    // Holding the counters clear throughout IDLE guarantees a fresh frame
    // starts at (0,0) whatever happened before.
    assign clear = (state == IDLE) | kill;

    median_scan_cnt #(.W(COL_W), .MAX(IMG_W - 1)) u_col (
        .clk   (clk),
        .reset (reset),
        .load  (clear),
        .inc   (advance),
        .count (col),
        .tc    (col_tc)
    );

    median_scan_cnt #(.W(ROW_W), .MAX(IMG_H - 1)) u_row (
        .clk   (clk),
        .reset (reset),
        .load  (clear),
        .inc   (advance & col_tc),
        .count (row),
        .tc    (row_tc)
    );

    median_scan_cnt #(.W(LB_SEL_W), .MAX(WIN - 2)) u_lb_sel (
        .clk   (clk),
        .reset (reset),
        .load  (clear),
        .inc   (advance & col_tc),
        .count (lb_sel),
        .tc    (unused_lb_tc)
    );

    // Frame FSM. All status outputs are registered here so they appear one
    // cycle after the accept that produced them; the per-pixel pulses
    // default low and are raised only on an accepted pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            win_valid_q <= 1'b0;
            eol_q       <= 1'b0;
            done_q      <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
        end else begin
            win_valid_q <= 1'b0;
            eol_q       <= 1'b0;
            done_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= RUN;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (kill) begin
                        state       <= IDLE;
                        pix_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end else if (advance) begin
                        eol_q <= col_tc;
                        // The accepted pixel is the bottom-right corner of
                        // the window, so the centre lies HALF up and left.
                        if (row >= ROW_FIRST && col >= COL_FIRST) begin
                            win_valid_q <= 1'b1;
                            win_row_q   <= row - ROW_HALF;
                            win_col_q   <= col - COL_HALF;
                        end
                        if (col_tc && row_tc) begin
                            state       <= DONE;
                            done_q      <= 1'b1;
                            pix_ready_q <= 1'b0;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pix_ready = pix_ready_q;
    assign bus.busy      = busy_q;
    assign bus.lb_wr_en  = accept;
    assign bus.lb_addr   = col;
    assign bus.lb_sel    = lb_sel;
    assign bus.win_valid = win_valid_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.eol       = eol_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_median_scan_ctrl.sv
// tb_median_scan_ctrl
// Self-checking bench for median_scan_ctrl on a small 8x6 image with a 3x3
// window. The expected raster position of every accepted pixel is derived
// from its index in the frame (row = k / IMG_W, col = k % IMG_W).
module tb_median_scan_ctrl;
    import median_pkg::*;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WIN   = 3;
    localparam int COL_W = 4;
    localparam int ROW_W = 3;
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int HALF  = (WIN - 1) / 2;
    localparam int EXP_WINDOWS = (IMG_W - WIN + 1) * (IMG_H - WIN + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef MEDIAN_SCAN_ABORT_EN
    logic abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    median_scan_ctrl_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    median_scan_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .COL_W (COL_W),
        .ROW_W (ROW_W),
        .WIN   (WIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MEDIAN_SCAN_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Pulse start for one cycle from IDLE and confirm the handshake opens.
    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        checks++;
        if (bus.pix_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pix_ready_pre_start got %b expected 0", bus.pix_ready);
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.pix_ready !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_entry got ready=%b busy=%b expected 1/1", bus.pix_ready, bus.busy);
        end
    endtask

    // Feed pixels until n_acc have been accepted. mode 0: pix_valid always
    // high; mode 1: every other cycle; mode 2: random pix_valid plus random
    // start pulses that the controller must ignore.
    task automatic run_frame(input int mode, input int n_acc);
        int k = 0;
        int cycles = 0;
        int win_cnt = 0;
        int eol_cnt = 0;
        int done_cnt = 0;
        int first_r = -1;
        int first_c = -1;
        int last_r = -1;
        int last_c = -1;
        int r;
        int c;
        logic pv;
        logic exp_wv;
        logic exp_eol;
        logic exp_done;
        while (k < n_acc && cycles < 1000) begin
            @(negedge clk);
            case (mode)
                0:       pv = 1'b1;
                1:       pv = ((cycles % 2) == 0);
                default: pv = ($urandom_range(0, 2) != 0);
            endcase
            bus.pix_valid = pv;
            bus.start = (mode == 2 && k < TOTAL - 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
            r = k / IMG_W;
            c = k % IMG_W;
            #1;
            checks++;
            if (bus.pix_ready !== 1'b1 || bus.busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL run_status k=%0d got ready=%b busy=%b expected 1/1", k, bus.pix_ready, bus.busy);
            end
            checks++;
            if (bus.lb_wr_en !== pv) begin
                errors++;
                $display("[TB] FAIL lb_wr_en k=%0d got %b expected %b", k, bus.lb_wr_en, pv);
            end
            checks++;
            if (bus.lb_addr !== COL_W'(c)) begin
                errors++;
                $display("[TB] FAIL lb_addr k=%0d got %0d expected %0d", k, bus.lb_addr, c);
            end
            checks++;
            if (bus.lb_sel !== LB_SEL_W'(r % (WIN - 1))) begin
                errors++;
                $display("[TB] FAIL lb_sel k=%0d got %0d expected %0d", k, bus.lb_sel, r % (WIN - 1));
            end

            @(posedge clk);
            #1;
            exp_wv   = pv && (r >= WIN - 1) && (c >= WIN - 1);
            exp_eol  = pv && (c == IMG_W - 1);
            exp_done = pv && (k == TOTAL - 1);
            checks++;
            if (bus.win_valid !== exp_wv) begin
                errors++;
                $display("[TB] FAIL win_valid k=%0d got %b expected %b", k, bus.win_valid, exp_wv);
            end
            checks++;
            if (bus.eol !== exp_eol) begin
                errors++;
                $display("[TB] FAIL eol k=%0d got %b expected %b", k, bus.eol, exp_eol);
            end
            checks++;
            if (bus.done !== exp_done) begin
                errors++;
                $display("[TB] FAIL done k=%0d got %b expected %b", k, bus.done, exp_done);
            end
            if (exp_wv) begin
                checks++;
                if (bus.win_row !== ROW_W'(r - HALF) || bus.win_col !== COL_W'(c - HALF)) begin
                    errors++;
                    $display("[TB] FAIL win_centre k=%0d got (%0d,%0d) expected (%0d,%0d)",
                             k, bus.win_row, bus.win_col, r - HALF, c - HALF);
                end
            end
            if (bus.win_valid === 1'b1) begin
                win_cnt++;
                if (first_r < 0) begin
                    first_r = int'(bus.win_row);
                    first_c = int'(bus.win_col);
                end
                last_r = int'(bus.win_row);
                last_c = int'(bus.win_col);
            end
            if (bus.eol === 1'b1) eol_cnt++;
            if (bus.done === 1'b1) done_cnt++;
            if (pv) k++;
            cycles++;
        end
        bus.pix_valid = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (k != n_acc) begin
            errors++;
            $display("[TB] FAIL frame_timeout got %0d accepts expected %0d", k, n_acc);
        end
        if (n_acc == TOTAL) begin
            checks++;
            if (win_cnt != EXP_WINDOWS) begin
                errors++;
                $display("[TB] FAIL win_count got %0d expected %0d", win_cnt, EXP_WINDOWS);
            end
            checks++;
            if (eol_cnt != IMG_H || done_cnt != 1) begin
                errors++;
                $display("[TB] FAIL eol_done_count got eol=%0d done=%0d expected %0d/1", eol_cnt, done_cnt, IMG_H);
            end
            checks++;
            if (first_r != HALF || first_c != HALF) begin
                errors++;
                $display("[TB] FAIL first_window got (%0d,%0d) expected (%0d,%0d)", first_r, first_c, HALF, HALF);
            end
            checks++;
            if (last_r != IMG_H - 1 - HALF || last_c != IMG_W - 1 - HALF) begin
                errors++;
                $display("[TB] FAIL last_window got (%0d,%0d) expected (%0d,%0d)",
                         last_r, last_c, IMG_H - 1 - HALF, IMG_W - 1 - HALF);
            end
        end
    endtask

    // After a completed frame: one DONE cycle with busy low, then IDLE.
    task automatic finish_frame();
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.pix_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_state got busy=%b ready=%b expected 0/0", bus.busy, bus.pix_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        bus.start = 1'b0;
        bus.pix_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.pix_ready, bus.busy, bus.win_valid, bus.eol, bus.done, bus.lb_wr_en} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b expected 000000",
                     {bus.pix_ready, bus.busy, bus.win_valid, bus.eol, bus.done, bus.lb_wr_en});
        end
        checks++;
        if (bus.lb_addr !== '0 || bus.lb_sel !== '0 || bus.win_row !== '0 || bus.win_col !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values got addr=%0d sel=%0d row=%0d col=%0d expected 0",
                     bus.lb_addr, bus.lb_sel, bus.win_row, bus.win_col);
        end
        reset = 1'b0;
    endtask

    task automatic test_idle_ignored();
        $display("[TB] test_idle_ignored");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.pix_valid = 1'b1;
            #1;
            checks++;
            if (bus.lb_wr_en !== 1'b0 || bus.lb_addr !== '0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_pixel got wr=%b addr=%0d busy=%b expected 0/0/0",
                         bus.lb_wr_en, bus.lb_addr, bus.busy);
            end
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic test_continuous();
        $display("[TB] test_continuous");
        do_start();
        run_frame(0, TOTAL);
        finish_frame();
    endtask

    task automatic test_toggle();
        $display("[TB] test_toggle");
        do_start();
        run_frame(1, TOTAL);
        finish_frame();
    endtask

    task automatic test_start_while_busy();
        $display("[TB] test_start_while_busy");
        do_start();
        run_frame(2, TOTAL);
        finish_frame();
    endtask

    task automatic test_back_to_back();
        $display("[TB] test_back_to_back");
        do_start();
        run_frame(0, TOTAL);
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done_busy got %b expected 0", bus.busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle_busy got %b expected 0", bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.lb_addr !== '0 || bus.lb_sel !== '0) begin
            errors++;
            $display("[TB] FAIL b2b_restart got busy=%b addr=%0d sel=%0d expected 1/0/0",
                     bus.busy, bus.lb_addr, bus.lb_sel);
        end
        run_frame(0, TOTAL);
        finish_frame();
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        do_start();
        run_frame(0, 19);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.pix_ready, bus.busy, bus.win_valid, bus.eol, bus.done, bus.lb_wr_en} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL midreset_flags got %b expected 000000",
                     {bus.pix_ready, bus.busy, bus.win_valid, bus.eol, bus.done, bus.lb_wr_en});
        end
        checks++;
        if (bus.lb_addr !== '0 || bus.lb_sel !== '0 || bus.win_row !== '0 || bus.win_col !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_values got addr=%0d sel=%0d row=%0d col=%0d expected 0",
                     bus.lb_addr, bus.lb_sel, bus.win_row, bus.win_col);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_quiet got done=%b busy=%b expected 0/0", bus.done, bus.busy);
            end
        end
        do_start();
        run_frame(2, TOTAL);
        finish_frame();
    endtask

`ifdef MEDIAN_SCAN_ABORT_EN
    task automatic test_abort();
        $display("[TB] test_abort");
        do_start();
        run_frame(0, 29);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.pix_ready, bus.win_valid, bus.eol, bus.done} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL abort_flags got %b expected 00000",
                     {bus.busy, bus.pix_ready, bus.win_valid, bus.eol, bus.done});
        end
        checks++;
        if (bus.lb_addr !== '0 || bus.lb_sel !== '0) begin
            errors++;
            $display("[TB] FAIL abort_counters got addr=%0d sel=%0d expected 0/0", bus.lb_addr, bus.lb_sel);
        end
        @(negedge clk);
        abort = 1'b0;
        bus.pix_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_quiet got done=%b busy=%b expected 0/0", bus.done, bus.busy);
            end
        end
        do_start();
        run_frame(0, TOTAL);
        finish_frame();
    endtask
`endif

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.pix_valid = 1'b0;
        test_reset();
        test_idle_ignored();
        test_continuous();
        test_toggle();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef MEDIAN_SCAN_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
